// File: rtl/bf2_pkg.sv
// Shared definitions for the radix-2 butterfly lane pipeline.
// Holds the default configuration, output-width and saturation-bound
// helpers, the stage-1 word type, and the round/saturate function
// used by stage 2 of bf2_lane_pipe.
package bf2_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_LANES = 16;
    localparam int DEF_GROW  = 0;

    // Output width: one extra bit for full-precision growth, otherwise the
    // result is squeezed back into the input width.
    function automatic int calc_ow(input int width, input int grow);
        return (grow != 0) ? width + 1 : width;
    endfunction

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

    localparam int OW      = calc_ow(DEF_WIDTH, DEF_GROW);
    localparam int SAT_MAX = sat_max(DEF_WIDTH);
    localparam int SAT_MIN = sat_min(DEF_WIDTH);

    // Stage-1 word: full-precision butterfly sum/difference.
    typedef logic signed [DEF_WIDTH:0] s1_word_t;

    // Turns a full-precision stage-1 value into the output value.
    // The result is returned sign-extended to 32 bits so one function serves
    // every WIDTH; callers truncate to OW. With scale_en the value is halved
    // rounding half up ((s+1) >>> 1). clip reports that saturation was applied.
    function automatic logic signed [31:0] round_sat(
        input  logic signed [31:0] s,
        input  logic               scale_en,
        input  int                 width,
        input  int                 grow,
        output logic               clip
    );
        logic signed [31:0] t;
        clip = 1'b0;
        if (grow != 0) begin
            t = s;
        end else begin
            t = scale_en ? ((s + 32'sd1) >>> 1) : s;
            if (t > sat_max(width)) begin
                t    = sat_max(width);
                clip = 1'b1;
            end else if (t < sat_min(width)) begin
                t    = sat_min(width);
                clip = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/bf2_lane_bf.sv
// Single-lane combinational radix-2 butterfly.
// Ports:
//   mode_ii_i          1 = rotate the second operand by -j
//   r1_i, q1_i         first operand (real, imaginary), signed WIDTH bits
//   r2_i, q2_i         second operand (real, imaginary), signed WIDTH bits
//   r_add_o .. q_sub_o full-precision results, signed WIDTH+1 bits
module bf2_lane
    import bf2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             mode_ii_i,
    input  logic [WIDTH-1:0] r1_i,
    input  logic [WIDTH-1:0] q1_i,
    input  logic [WIDTH-1:0] r2_i,
    input  logic [WIDTH-1:0] q2_i,
    output logic [WIDTH:0]   r_add_o,
    output logic [WIDTH:0]   r_sub_o,
    output logic [WIDTH:0]   q_add_o,
    output logic [WIDTH:0]   q_sub_o
);

    logic signed [WIDTH:0] r1X;
    logic signed [WIDTH:0] q1X;
    logic signed [WIDTH:0] r2X;
    logic signed [WIDTH:0] q2X;
    logic signed [WIDTH:0] bR;
    logic signed [WIDTH:0] bQ;

    // Everything is widened by one bit first, so negating the most negative
    // input and the sums themselves all fit without wrap-around.
    // Multiplying (R2 + jQ2) by -j gives (Q2, -R2).
    always_comb begin
        r1X     = {r1_i[WIDTH-1], r1_i};
        q1X     = {q1_i[WIDTH-1], q1_i};
        r2X     = {r2_i[WIDTH-1], r2_i};
        q2X     = {q2_i[WIDTH-1], q2_i};
        bR      = mode_ii_i ? q2X : r2X;
        bQ      = mode_ii_i ? -r2X : q2X;
        r_add_o = r1X + bR;
        r_sub_o = r1X - bR;
        q_add_o = q1X + bQ;
        q_sub_o = q1X - bQ;
    end

endmodule

// File: rtl/bf2_lane_pipe.sv
// LANES parallel radix-2 butterflies with a 2-stage valid/ready pipeline.
// Stage 1 registers full-precision sums/differences; stage 2 registers the
// rounded/saturated (or grown) outputs and drives the sticky overflow flag.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input beat handshake
//   mode_ii, scale_en      per-beat controls, sampled with the beat
//   din_R1..din_Q2         LANES x WIDTH packed operand buses (lane 0 in LSBs)
//   out_valid / out_ready  output beat handshake
//   dout_R_add..dout_Q_sub LANES x OW packed result buses
//   ovf_flag, ovf_clr      sticky saturation flag and its synchronous clear
module bf2_lane_pipe
    import bf2_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int LANES = DEF_LANES,
    parameter  int GROW  = DEF_GROW,
    localparam int OW    = calc_ow(WIDTH, GROW)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode_ii,
    input  logic                   scale_en,
    input  logic [LANES*WIDTH-1:0] din_R1,
    input  logic [LANES*WIDTH-1:0] din_Q1,
    input  logic [LANES*WIDTH-1:0] din_R2,
    input  logic [LANES*WIDTH-1:0] din_Q2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OW-1:0]    dout_R_add,
    output logic [LANES*OW-1:0]    dout_R_sub,
    output logic [LANES*OW-1:0]    dout_Q_add,
    output logic [LANES*OW-1:0]    dout_Q_sub,
    output logic                   ovf_flag,
    input  logic                   ovf_clr
);

    localparam int S1W = WIDTH + 1;

    // Index 0..3 = R_add, R_sub, Q_add, Q_sub throughout.
    logic [3:0][LANES*S1W-1:0] laneRes;
    logic [3:0][LANES*S1W-1:0] s1_q;
    logic                      scale1_q;
    logic                      v1_q;
    logic [3:0][LANES*OW-1:0]  dout_d;
    logic [3:0][LANES*OW-1:0]  dout_q;
    logic                      v2_q;
    logic                      ovf_q;
    logic                      clipAny_d;
    logic signed [S1W-1:0]     word;
    logic                      laneClip;
    logic                      load1;
    logic                      load2;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bf2_lane #(.WIDTH(WIDTH)) u_lane (
            .mode_ii_i (mode_ii),
            .r1_i      (din_R1[g*WIDTH +: WIDTH]),
            .q1_i      (din_Q1[g*WIDTH +: WIDTH]),
            .r2_i      (din_R2[g*WIDTH +: WIDTH]),
            .q2_i      (din_Q2[g*WIDTH +: WIDTH]),
            .r_add_o   (laneRes[0][g*S1W +: S1W]),
            .r_sub_o   (laneRes[1][g*S1W +: S1W]),
            .q_add_o   (laneRes[2][g*S1W +: S1W]),
            .q_sub_o   (laneRes[3][g*S1W +: S1W])
        );
    end

    // Each stage advances when it is empty or the stage after it is moving,
    // which gives full throughput and lets a full pipe drain and accept in the
    // same cycle. in_ready is exactly the stage-1 load condition.
    assign load2    = !v2_q || out_ready;
    assign load1    = !v1_q || load2;
    assign in_ready = load1;

    // Stage 1: capture the lane results together with the beat's scale choice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            scale1_q <= 1'b0;
            v1_q     <= 1'b0;
        end else if (load1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_q     <= laneRes;
                scale1_q <= scale_en;
            end
        end
    end

    // Round/saturate every value of the stage-1 beat and OR the clip bits
    // across all lanes, so one clipped value anywhere flags the whole beat.
    always_comb begin
        dout_d    = '0;
        clipAny_d = 1'b0;
        word      = '0;
        laneClip  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < LANES; i++) begin
                word = s1_q[k][i*S1W +: S1W];
                dout_d[k][i*OW +: OW] = OW'(round_sat(32'(word), scale1_q, WIDTH, GROW, laneClip));
                clipAny_d = clipAny_d | laneClip;
            end
        end
    end

    // Stage 2 only updates its data when a real beat arrives, so outputs stay
    // put while stalled. A clipping beat landing here sets the sticky flag,
    // and that set takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            v2_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (load2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    dout_q <= dout_d;
                end
            end
            if (load2 && v1_q && clipAny_d) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_valid  = v2_q;
    assign dout_R_add = dout_q[0];
    assign dout_R_sub = dout_q[1];
    assign dout_Q_add = dout_q[2];
    assign dout_Q_sub = dout_q[3];
    assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_bf2_lane_pipe.sv
// Directed self-checking bench for bf2_lane_pipe (WIDTH=9, LANES=16, GROW=0).
module tb_bf2_lane_pipe;

    localparam int WIDTH = 9;
    localparam int LANES = 16;
    localparam int OW    = 9;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic                   mode_ii;
    logic                   scale_en;
    logic [LANES*WIDTH-1:0] din_R1;
    logic [LANES*WIDTH-1:0] din_Q1;
    logic [LANES*WIDTH-1:0] din_R2;
    logic [LANES*WIDTH-1:0] din_Q2;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OW-1:0]    dout_R_add;
    logic [LANES*OW-1:0]    dout_R_sub;
    logic [LANES*OW-1:0]    dout_Q_add;
    logic [LANES*OW-1:0]    dout_Q_sub;
    logic                   ovf_flag;
    logic                   ovf_clr;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    bf2_lane_pipe #(.WIDTH(WIDTH), .LANES(LANES), .GROW(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode_ii    (mode_ii),
        .scale_en   (scale_en),
        .din_R1     (din_R1),
        .din_Q1     (din_Q1),
        .din_R2     (din_R2),
        .din_Q2     (din_Q2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout_R_add (dout_R_add),
        .dout_R_sub (dout_R_sub),
        .dout_Q_add (dout_Q_add),
        .dout_Q_sub (dout_Q_sub),
        .ovf_flag   (ovf_flag),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int laneVal(input logic [LANES*OW-1:0] bus, input int lane);
        logic signed [OW-1:0] v;
        v = bus[lane*OW +: OW];
        return int'(v);
    endfunction

    task automatic checkValue(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int ra, input int rs, input int qa, input int qs);
        int lanes[2];
        lanes[0] = 0;
        lanes[1] = LANES - 1;
        foreach (lanes[n]) begin
            checkValue($sformatf("%s_l%0d_Radd", tag, lanes[n]), laneVal(dout_R_add, lanes[n]), ra);
            checkValue($sformatf("%s_l%0d_Rsub", tag, lanes[n]), laneVal(dout_R_sub, lanes[n]), rs);
            checkValue($sformatf("%s_l%0d_Qadd", tag, lanes[n]), laneVal(dout_Q_add, lanes[n]), qa);
            checkValue($sformatf("%s_l%0d_Qsub", tag, lanes[n]), laneVal(dout_Q_sub, lanes[n]), qs);
        end
    endtask

    task automatic setOperands(input int r1, input int q1, input int r2, input int q2,
                               input logic mode, input logic scale);
        for (int i = 0; i < LANES; i++) begin
            din_R1[i*WIDTH +: WIDTH] = WIDTH'(r1);
            din_Q1[i*WIDTH +: WIDTH] = WIDTH'(q1);
            din_R2[i*WIDTH +: WIDTH] = WIDTH'(r2);
            din_Q2[i*WIDTH +: WIDTH] = WIDTH'(q2);
        end
        mode_ii  = mode;
        scale_en = scale;
    endtask

    // Presents one beat, lets it be accepted, and waits until it sits in
    // stage 2 (two edges later); called from just after an active edge.
    task automatic applyStimulus(input int r1, input int q1, input int r2, input int q2,
                                 input logic mode, input logic scale);
        setOperands(r1, q1, r2, q2, mode, scale);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clearFlag(input string tag);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        checkValue(tag, ovf_flag, 0);
    endtask

    initial begin
        int   k;
        int   got;
        int   heldVal;
        logic held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        din_R1    = '0;
        din_Q1    = '0;
        din_R2    = '0;
        din_Q2    = '0;
        mode_ii   = 1'b0;
        scale_en  = 1'b0;

        // Reset state
        #3;
        checkValue("rst_outValid", out_valid, 0);
        checkValue("rst_ovf", ovf_flag, 0);
        checkOutput("rst", 0, 0, 0, 0);
        #9;
        rst_n = 1'b1;
        #1;
        checkValue("rst_inReady", in_ready, 1);
        @(posedge clk);
        #1;

        // Mode I, no scaling
        applyStimulus(100, -20, 50, 30, 1'b0, 1'b0);
        checkValue("m1_outValid", out_valid, 1);
        checkOutput("m1", 150, 50, 10, -50);
        checkValue("m1_ovf", ovf_flag, 0);

        // Positive saturation
        applyStimulus(200, 0, 100, 0, 1'b0, 1'b0);
        checkOutput("satPos", 255, 100, 0, 0);
        checkValue("satPos_ovf", ovf_flag, 1);
        clearFlag("satPos_clr");

        // Negative saturation
        applyStimulus(-200, 0, 100, 0, 1'b0, 1'b0);
        checkOutput("satNeg", -100, -256, 0, 0);
        checkValue("satNeg_ovf", ovf_flag, 1);
        clearFlag("satNeg_clr");

        // Clear held high while a clipping beat lands: set must win
        ovf_clr = 1'b1;
        applyStimulus(200, 0, 100, 0, 1'b0, 1'b0);
        ovf_clr = 1'b0;
        checkValue("setWins_ovf", ovf_flag, 1);
        clearFlag("setWins_clr");

        // Scaling with round half up
        applyStimulus(3, 0, 2, 0, 1'b0, 1'b1);
        checkOutput("scale1", 3, 1, 0, 0);
        checkValue("scale1_ovf", ovf_flag, 0);
        applyStimulus(-3, 0, 0, 0, 1'b0, 1'b1);
        checkOutput("scale2", -1, -1, 0, 0);

        // Mode II with scaling: Q1 + 256 = 511 -> 256 -> clipped to 255
        applyStimulus(0, 255, -256, 0, 1'b1, 1'b1);
        checkOutput("m2scale", 0, 0, 255, 0);
        checkValue("m2scale_ovf", ovf_flag, 1);
        clearFlag("m2scale_clr");

        // Mode II, no scaling
        applyStimulus(10, 20, 3, 4, 1'b1, 1'b0);
        checkOutput("m2", 14, 6, 17, 23);
        checkValue("m2_ovf", ovf_flag, 0);
        @(posedge clk);
        #1;

        // Backpressure: beats 1..5 with out_ready low during cycles 2..5
        k       = 1;
        got     = 0;
        held    = 1'b0;
        heldVal = 0;
        for (int c = 1; c <= 40 && got < 5; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (k <= 5);
            setOperands(k, 0, 0, 0, 1'b0, 1'b0);
            #1;
            if (held) begin
                checkValue("bp_holdValid", out_valid, 1);
                checkValue("bp_holdData", laneVal(dout_R_add, 0), heldVal);
            end
            if (c == 3) begin
                checkValue("bp_inReadyLow", in_ready, 0);
            end
            held    = out_valid && !out_ready;
            heldVal = laneVal(dout_R_add, 0);
            if (out_valid && out_ready) begin
                got++;
                checkValue("bp_order", laneVal(dout_R_add, 0), got);
            end
            if (in_valid && in_ready) begin
                k++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkValue("bp_count", got, 5);
        @(posedge clk);
        #1;
        checkValue("bp_noDup", out_valid, 0);

        // Fill both stages (one clipping beat), then reset mid-stream
        out_ready = 1'b0;
        setOperands(200, 0, 100, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        setOperands(7, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkValue("full_outValid", out_valid, 1);
        checkValue("full_inReady", in_ready, 0);
        checkValue("full_ovf", ovf_flag, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("midRst_outValid", out_valid, 0);
        checkValue("midRst_ovf", ovf_flag, 0);
        checkOutput("midRst", 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        #1;
        checkValue("midRst_inReady", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checkValue("midRst_noStale", out_valid, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bf2_lane_pipe.md
Name: bf2_lane_pipe

Overview:
- Next-generation radix-2 butterfly stage for the FFT datapath: LANES parallel complex butterflies (R = real, Q = imaginary) with a valid/ready handshake and a 2-deep pipeline with backpressure.
- A runtime BF2II mode rotates the second operand by -j.
- Output can grow by one bit, or stay WIDTH bits with optional /2 scaling, rounding and saturation, plus a sticky overflow flag.
- Sits between the input reorder buffer and the twiddle multiplier, replacing the fixed-latency, non-handshaked BF2I.

Parameters:
- WIDTH, 9, input sample width per component (signed).
- LANES, 16, parallel butterflies per beat.
- GROW, 0, 0: output width OW = WIDTH with scale/saturate; 1: OW = WIDTH+1, full precision.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- mode_ii  in  1  sampled with the beat; 1 = apply -j to the second operand.
- scale_en  in  1  sampled with the beat; 1 = divide by 2 with rounding (ignored when GROW=1).
- din_R1, din_Q1, din_R2, din_Q2  in  signed [WIDTH-1:0] x LANES  operand pairs.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub  out  signed [OW-1:0] x LANES  butterfly results.
- ovf_flag  out  1  sticky: a saturation has occurred.
- ovf_clr  in  1  synchronous clear of ovf_flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All data outputs are 0; out_valid = 0; stage-1 valid v1 = 0; stage-2 valid v2 = 0; ovf_flag = 0.
  - in_ready = 1 as soon as reset is released.
- Operand selection, per lane:
  - mode_ii = 0: second operand (B_R, B_Q) = (R2, Q2).
  - mode_ii = 1: (B_R, B_Q) = (Q2, -R2).
  - Computed in WIDTH+1 bits, so -(-2^(WIDTH-1)) cannot overflow.
- Stage 1 (register):
  - R_add = R1 + B_R; R_sub = R1 - B_R; Q_add = Q1 + B_Q; Q_sub = Q1 - B_Q.
  - All results are full precision, WIDTH+1 bits, and are registered together with the sampled scale_en.
- Stage 2 (register), per value s:
  - GROW=1: output s unchanged; ovf never set.
  - GROW=0 with scale_en: t = (s + 1) >>> 1 (round half up, arithmetic shift); otherwise t = s.
  - GROW=0: saturate t to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Any clipped value in any lane of the beat is a saturation event.
- Latency: 2 cycles from the accepting edge to out_valid, when not stalled.
- Handshake:
  - Stage 2 loads when !v2 || out_ready.
  - Stage 1 loads when !v1 || (stage 2 loads).
  - in_ready = !v1 || !v2 || out_ready (combinational).
  - No bubbles at steady state: 1 beat/cycle throughput.
  - Outputs and out_valid hold stable while out_valid && !out_ready.
  - Beats are never dropped or duplicated; order is preserved.
- Overflow flag:
  - ovf_flag sets on the cycle a saturating beat is registered into stage 2.
  - ovf_clr clears it.
  - Set and clear in the same cycle: set wins.
- Boundaries:
  - in_valid with in_ready low: no capture; the upstream must hold its data.
  - Reset mid-stream flushes both stages; in-flight beats are lost.
  - Simultaneous output drain and input accept while full is allowed (pipe stays full).

Decomposition:
- Package bf2_pkg holds:
  - localparams OW(WIDTH, GROW), SAT_MAX and SAT_MIN;
  - typedef for the stage-1 word (signed WIDTH+1);
  - function round_sat(s, scale_en) returning the OW-bit result and a clip bit.
- Sub-module bf2_lane: combinational single-lane operand select plus the four add/sub results. Generated LANES times.
- The parent owns the pipeline registers, handshake and ovf_flag.

Test Plan (WIDTH=9, GROW=0, range -256..255):
- Reset mid-stream with both stages full -> out_valid=0, all outputs 0, ovf_flag=0, in_ready=1 after release; no stale beat emerges.
- mode I, scale off, R1=100, R2=50, Q1=-20, Q2=30 -> 2 cycles later R_add=150, R_sub=50, Q_add=10, Q_sub=-50, ovf_flag=0.
- Saturation: R1=200, R2=100 -> R_add=255, ovf_flag=1. R1=-200, R2=100 -> R_sub=-256. Pulsing ovf_clr on the same cycle as a new clip -> flag stays 1.
- Scale: R1=3, R2=2 -> R_add=3, R_sub=1. R1=-3, R2=0 -> R_add=-1. mode II with Q1=255, R2=-256 -> Q_add=255 (clipped from 256), ovf_flag=1.
- mode II, scale off, R1=10, Q1=20, R2=3, Q2=4 -> R_add=14, R_sub=6, Q_add=17, Q_sub=23.
- Backpressure: stream beats 1..5 (R1=k, others 0) with out_ready low for cycles 2-5 -> in_ready drops after 2 beats are held, outputs stay stable, then R_add = 1, 2, 3, 4, 5 emerge in order with no loss or duplication.
